mvd_cand_sched: RTL
===================

Name: mvd_cand_sched

Overview:
- Sequencer that shares one mvd_getBits datapath across all AMVP candidates of a PU.
- For each candidate it presents one mv/mvp pair per cycle and reads back the bit estimate and MVD.
- It keeps the lowest-cost valid candidate and returns its index, bit count and MVD.
- Sits between FME/MVP-list generation and the mode-decision cost adder in rec_mc.

Parameters:
- FMV_WIDTH, 10: width of one MV component (x or y), two's complement.
- MVD_WIDTH, 11: width of one MVD component returned by the datapath.
- CAND_NUM, 2: number of AMVP candidates evaluated per request, at least 2.
- IDX_WIDTH, 1: candidate index width, equal to clog2(CAND_NUM).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request pulse. Accepted only when busy_o is 0.
- mv_i  in  2*FMV_WIDTH  {y,x} final MV to be coded.
- mvp_cand_i  in  CAND_NUM*2*FMV_WIDTH  candidate k is at bits [k*2*FMV_WIDTH +: 2*FMV_WIDTH], {y,x}.
- cand_valid_i  in  CAND_NUM  per-candidate valid flag.
- dp_mv_o  out  2*FMV_WIDTH  MV driven to the datapath.
- dp_mvp_o  out  2*FMV_WIDTH  MVP driven to the datapath.
- dp_bits_i  in  7  combinational bit count returned by the datapath.
- dp_mvd_i  in  2*MVD_WIDTH  combinational {x,y} MVD returned by the datapath.
- busy_o  out  1  high while evaluating.
- done_o  out  1  one-cycle result strobe.
- best_idx_o  out  IDX_WIDTH  selected candidate index.
- best_bits_o  out  7  bits of the selected candidate.
- best_mvd_o  out  2*MVD_WIDTH  MVD of the selected candidate.
- no_cand_o  out  1  set when no candidate was valid.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE. Internal cand_cnt=0. Outputs: busy_o=0, done_o=0, best_idx_o=0, best_bits_o=7'h7F, best_mvd_o=0, no_cand_o=0. dp_mv_o and dp_mvp_o reset to 0.
- States: IDLE, EVAL, DONE.
- IDLE:
  - On start_i=1: latch mv_i, mvp_cand_i and cand_valid_i.
  - Clear cand_cnt and the working best (bits=7'h7F, idx=0, mvd=0, found=0).
  - Go to EVAL.
- EVAL (busy_o=1):
  - dp_mv_o = latched mv. dp_mvp_o = latched candidate[cand_cnt]. Both are driven from registers, valid for the whole cycle.
  - At the clock edge, if valid[cand_cnt]=1 and dp_bits_i < working bits (strict): update working bits, idx=cand_cnt and mvd=dp_mvd_i, and set found=1.
  - Ties keep the lower index.
  - Invalid candidates are skipped, but each still consumes one cycle, so EVAL is always exactly CAND_NUM cycles.
  - When cand_cnt=CAND_NUM-1: register the working best into the best_* outputs, set no_cand_o=~found_next, and go to DONE.
  - Otherwise cand_cnt increments.
- DONE:
  - done_o=1 for exactly one cycle. busy_o=0.
  - start_i is accepted here with the same action as in IDLE, giving back-to-back requests.
  - Otherwise go to IDLE.
- Latency: start accepted at edge T0. EVAL cycles run T1..T_CAND_NUM. done_o is high in cycle T_CAND_NUM+1. Throughput is one request per CAND_NUM+1 cycles.
- Input changes: start_i while busy_o=1 is ignored, with no queueing. Input changes after acceptance do not affect the running request.
- Result hold: best_* and no_cand_o hold their values from done_o until the next request's final EVAL edge.
- No valid candidate: best_idx_o=0, best_bits_o=7'h7F, best_mvd_o=0, no_cand_o=1, and done_o still pulses.
- Arithmetic: the datapath maximum is 126, so the 7'h7F sentinel is always beaten by any valid candidate. The comparison is 7-bit unsigned.
- Reset mid-operation: rst_n low in any state immediately forces the reset values. No done_o is produced for the aborted request.
- In IDLE and DONE, dp_mv_o and dp_mvp_o hold their last values; the datapath output is don't-care there.

Test Plan:
- Reset: rst_n low, then released. Expect all outputs at reset values and state IDLE. A start issued one cycle after release is accepted.
- Two valid candidates, mv=(x=5,y=0), cand0=(x=5,y=0), cand1=(x=4,y=0), using a reference datapath model:
  - Datapath sees cand0 (bits 2) at T1 and cand1 (bits 4) at T2.
  - done_o is high at T3 with best_idx_o=0, best_bits_o=2, best_mvd_o=0, no_cand_o=0.
- Tie: cand0=cand1=(x=3,y=-2). Expect best_idx_o=0. Then swap to cand0=(x=0,y=0), cand1=mv. Expect best_idx_o=1, best_bits_o=2.
- Valid mask: cand_valid_i=2'b10 with cand0=mv. Expect best_idx_o=1. With mask 2'b00: no_cand_o=1, best_bits_o=127, best_mvd_o=0, done_o pulses at T3.
- Back-to-back: start held high. Expect requests accepted every 3 cycles, and the done_o cycle coinciding with acceptance of the next request. A start during EVAL is ignored, with no extra done_o.
- Abort: rst_n asserted during cycle T1 of EVAL. Expect outputs at reset values asynchronously and no done_o. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/mvd_cand_sched.sv
// mvd_cand_sched: shares one mvd_getBits datapath across AMVP candidates and keeps the cheapest valid one
module mvd_cand_sched #(
    parameter int FMV_WIDTH = 10,
    parameter int MVD_WIDTH = 11,
    parameter int CAND_NUM  = 2,
    parameter int IDX_WIDTH = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic [2*FMV_WIDTH-1:0]          mv_i,
    input  logic [CAND_NUM*2*FMV_WIDTH-1:0] mvp_cand_i,
    input  logic [CAND_NUM-1:0]             cand_valid_i,
    output logic [2*FMV_WIDTH-1:0]          dp_mv_o,
    output logic [2*FMV_WIDTH-1:0]          dp_mvp_o,
    input  logic [6:0]                      dp_bits_i,
    input  logic [2*MVD_WIDTH-1:0]          dp_mvd_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [IDX_WIDTH-1:0]            best_idx_o,
    output logic [6:0]                      best_bits_o,
    output logic [2*MVD_WIDTH-1:0]          best_mvd_o,
    output logic                            no_cand_o
);
    localparam logic [1:0] IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2;
    localparam int MW = 2 * FMV_WIDTH;
    logic [1:0]                 state;
    logic [IDX_WIDTH-1:0]       cand_cnt;
    logic [CAND_NUM*MW-1:0]     cand_q;
    logic [CAND_NUM-1:0]        valid_q;
    logic [6:0]                 wk_bits, bits_n;
    logic [IDX_WIDTH-1:0]       wk_idx, idx_n;
    logic [2*MVD_WIDTH-1:0]     wk_mvd, mvd_n;
    logic                       found, found_n, upd, last, accept;
    assign busy_o = state == EVAL;
    assign done_o = state == DONE;
    always_comb begin
        accept  = start_i && state != EVAL;
        last    = cand_cnt == IDX_WIDTH'(CAND_NUM - 1);
        upd     = valid_q[cand_cnt] && dp_bits_i < wk_bits;
        bits_n  = upd ? dp_bits_i : wk_bits;
        idx_n   = upd ? cand_cnt : wk_idx;
        mvd_n   = upd ? dp_mvd_i : wk_mvd;
        found_n = found | upd;
    end
    // dp_mv_o doubles as the latched request MV; dp_mvp_o is preloaded one candidate ahead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cand_cnt    <= '0;
            cand_q      <= '0;
            valid_q     <= '0;
            dp_mv_o     <= '0;
            dp_mvp_o    <= '0;
            wk_bits     <= 7'h7F;
            wk_idx      <= '0;
            wk_mvd      <= '0;
            found       <= 1'b0;
            best_idx_o  <= '0;
            best_bits_o <= 7'h7F;
            best_mvd_o  <= '0;
            no_cand_o   <= 1'b0;
        end else if (accept) begin
            state    <= EVAL;
            cand_cnt <= '0;
            cand_q   <= mvp_cand_i;
            valid_q  <= cand_valid_i;
            dp_mv_o  <= mv_i;
            dp_mvp_o <= mvp_cand_i[MW-1:0];
            wk_bits  <= 7'h7F;
            wk_idx   <= '0;
            wk_mvd   <= '0;
            found    <= 1'b0;
        end else if (state == EVAL) begin
            wk_bits <= bits_n;
            wk_idx  <= idx_n;
            wk_mvd  <= mvd_n;
            found   <= found_n;
            if (last) begin
                state       <= DONE;
                best_bits_o <= bits_n;
                best_idx_o  <= idx_n;
                best_mvd_o  <= mvd_n;
                no_cand_o   <= ~found_n;
            end else begin
                cand_cnt <= cand_cnt + 1'b1;
                dp_mvp_o <= cand_q[(int'(cand_cnt) + 1) * MW +: MW];
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule
